// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: trains the serial PHY link, gates user traffic onto it and recovers or retrains on sync loss.
module phy_link_ctrl #(
  parameter logic [31:0] COM_WORD      = 32'hBCBCBCBC,
  parameter logic [31:0] IDLE_WORD     = 32'h7C7C7C7C,
  parameter int          TRAIN_MIN     = 16,
  parameter int          SYNC_CONSEC   = 4,
  parameter int          LOSS_LIMIT    = 8,
  parameter int          TRAIN_TIMEOUT = 255
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic [31:0] usr_data_in,
  input  logic        usr_valid_in,
  output logic        usr_ready_out,
  output logic [31:0] tx_data_out,
  output logic        tx_valid_out,
  input  logic        rx_sync_in,
  output logic        sincronizar_bus,
  output logic        link_up,
  output logic [1:0]  state_out,
  output logic [7:0]  retrain_count,
  output logic        train_timeout
);
  localparam int TCW = $clog2(TRAIN_MIN + 1);
  localparam int SCW = $clog2(SYNC_CONSEC + 1);
  localparam int TMW = $clog2(TRAIN_TIMEOUT + 1);
  localparam int LCW = $clog2(LOSS_LIMIT + 1);
  typedef enum logic [1:0] {S_INIT, S_TRAIN, S_ACTIVE, S_RECOVER} state_t;
  state_t r_state, w_state;
  logic [TCW-1:0] r_train_cnt, w_train_cnt, w_tc_inc;
  logic [SCW-1:0] r_consec, w_consec, w_cs_inc;
  logic [TMW-1:0] r_train_tmr, w_train_tmr, w_tm_inc;
  logic [LCW-1:0] r_loss_cnt, w_loss_cnt, w_loss_inc;
  logic [7:0]     r_retrain, w_retrain;
  logic           r_timeout, w_timeout;
  logic [31:0]    r_tx_data, w_tx_data;
  logic           r_tx_valid, w_tx_valid;
  logic           w_send_usr;
  // saturating candidate values; the FSM decides which ones are committed
  assign w_tc_inc   = (r_train_cnt == TCW'(TRAIN_MIN)) ? r_train_cnt : r_train_cnt + 1'b1;
  assign w_cs_inc   = !rx_sync_in ? '0 : (r_consec == SCW'(SYNC_CONSEC)) ? r_consec : r_consec + 1'b1;
  assign w_tm_inc   = r_train_tmr + 1'b1;
  assign w_loss_inc = r_loss_cnt + 1'b1;
  assign w_send_usr = (r_state == S_ACTIVE) && usr_valid_in;
  always_comb begin
    w_state     = r_state;
    w_train_cnt = r_train_cnt;
    w_consec    = r_consec;
    w_train_tmr = r_train_tmr;
    w_loss_cnt  = r_loss_cnt;
    w_retrain   = r_retrain;
    w_timeout   = 1'b0;
    w_tx_data   = (r_state == S_TRAIN) ? COM_WORD : w_send_usr ? usr_data_in : IDLE_WORD;
    w_tx_valid  = (r_state == S_TRAIN) || w_send_usr;
    case (r_state)
      S_INIT: begin
        w_state     = S_TRAIN;
        w_train_cnt = '0;
        w_consec    = '0;
        w_train_tmr = '0;
        w_loss_cnt  = '0;
      end
      S_TRAIN: begin
        w_train_cnt = '0;
        w_consec    = '0;
        w_train_tmr = '0;
        if (w_tc_inc == TCW'(TRAIN_MIN) && w_cs_inc == SCW'(SYNC_CONSEC)) begin
          w_state = S_ACTIVE;
        end else if (w_tm_inc == TMW'(TRAIN_TIMEOUT)) begin
          w_timeout = 1'b1;
        end else begin
          w_train_cnt = w_tc_inc;
          w_consec    = w_cs_inc;
          w_train_tmr = w_tm_inc;
        end
      end
      S_ACTIVE: begin
        w_state    = rx_sync_in ? S_ACTIVE : S_RECOVER;
        w_loss_cnt = rx_sync_in ? '0 : LCW'(1);
      end
      S_RECOVER: begin
        if (rx_sync_in) begin
          w_state    = S_ACTIVE;
          w_loss_cnt = '0;
        end else if (w_loss_inc == LCW'(LOSS_LIMIT)) begin
          w_state     = S_TRAIN;
          w_loss_cnt  = '0;
          w_train_cnt = '0;
          w_consec    = '0;
          w_train_tmr = '0;
          w_retrain   = (r_retrain == 8'hFF) ? r_retrain : r_retrain + 1'b1;
        end else begin
          w_loss_cnt = w_loss_inc;
        end
      end
      default: w_state = S_INIT;
    endcase
  end
  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_train_cnt <= '0;
      r_consec    <= '0;
      r_train_tmr <= '0;
      r_loss_cnt  <= '0;
      r_retrain   <= '0;
      r_timeout   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_train_cnt <= w_train_cnt;
      r_consec    <= w_consec;
      r_train_tmr <= w_train_tmr;
      r_loss_cnt  <= w_loss_cnt;
      r_retrain   <= w_retrain;
      r_timeout   <= w_timeout;
      r_tx_data   <= w_tx_data;
      r_tx_valid  <= w_tx_valid;
    end
  end
  assign usr_ready_out   = r_state == S_ACTIVE;
  assign link_up         = r_state == S_ACTIVE;
  assign sincronizar_bus = r_state == S_TRAIN;
  assign state_out       = r_state;
  assign retrain_count   = r_retrain;
  assign train_timeout   = r_timeout;
  assign tx_data_out     = r_tx_data;
  assign tx_valid_out    = r_tx_valid;
endmodule

// File: tb/tb_phy_link_ctrl.sv
// tb_phy_link_ctrl: randomized stimulus, behavioural link model and scoreboard for phy_link_ctrl.
module tb_phy_link_ctrl;
  localparam logic [31:0] COM  = 32'hBCBCBCBC;
  localparam logic [31:0] IDLE = 32'h7C7C7C7C;
  logic        clk_f = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] usr_data_in = '0;
  logic        usr_valid_in = 1'b0;
  logic        usr_ready_out;
  logic [31:0] tx_data_out;
  logic        tx_valid_out;
  logic        rx_sync_in = 1'b0;
  logic        sincronizar_bus;
  logic        link_up;
  logic [1:0]  state_out;
  logic [7:0]  retrain_count;
  logic        train_timeout;
  phy_link_ctrl dut (
    .clk_f(clk_f), .reset(reset), .usr_data_in(usr_data_in), .usr_valid_in(usr_valid_in),
    .usr_ready_out(usr_ready_out), .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .rx_sync_in(rx_sync_in), .sincronizar_bus(sincronizar_bus), .link_up(link_up),
    .state_out(state_out), .retrain_count(retrain_count), .train_timeout(train_timeout)
  );
  always #5 clk_f = ~clk_f;
  logic [46:0] sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc_no = 0;
  // model of the link: mode 0 INIT, 1 TRAIN, 2 ACTIVE, 3 RECOVER
  int m_st = 0, m_cycles = 0, m_highs = 0, m_age = 0, m_lows = 0, m_rc = 0;
  bit m_to = 0, m_txv = 0;
  logic [31:0] m_txd = '0;
  task automatic enter_train();
    m_st = 1;
    m_cycles = 0;
    m_highs = 0;
    m_age = 0;
  endtask
  task automatic model_step(input bit rst, input bit rx, input bit uv, input logic [31:0] ud);
    if (rst) begin
      m_st = 0; m_cycles = 0; m_highs = 0; m_age = 0; m_lows = 0; m_rc = 0;
      m_to = 0; m_txv = 0; m_txd = '0;
      return;
    end
    m_txv = (m_st == 1) || (m_st == 2 && uv);
    m_txd = (m_st == 1) ? COM : (m_st == 2 && uv) ? ud : IDLE;
    m_to = 0;
    if (m_st == 0) begin
      enter_train();
      m_lows = 0;
    end else if (m_st == 1) begin
      m_cycles = (m_cycles + 1 > 16) ? 16 : m_cycles + 1;
      m_highs = rx ? ((m_highs + 1 > 4) ? 4 : m_highs + 1) : 0;
      m_age = m_age + 1;
      if (m_cycles == 16 && m_highs == 4) begin
        enter_train();
        m_st = 2;
      end else if (m_age == 255) begin
        m_to = 1;
        enter_train();
      end
    end else if (m_st == 2) begin
      if (!rx) begin m_st = 3; m_lows = 1; end
    end else begin
      m_lows = rx ? 0 : m_lows + 1;
      if (rx) m_st = 2;
      else if (m_lows == 8) begin
        m_lows = 0;
        m_rc = (m_rc == 255) ? 255 : m_rc + 1;
        enter_train();
      end
    end
  endtask
  task automatic cyc(input bit rst, input bit rx);
    logic [46:0] e;
    reset = rst;
    rx_sync_in = rx;
    usr_valid_in = 1'($urandom_range(0, 1));
    usr_data_in = $urandom;
    model_step(rst, rx, usr_valid_in, usr_data_in);
    e = {m_txd, m_txv, 2'(m_st), m_st == 2, m_st == 2, m_st == 1, 8'(m_rc), m_to};
    sb_q.push_back(e);
    @(posedge clk_f);
    #1;
  endtask
  task automatic hold(input bit rx, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rx);
  endtask
  always @(negedge clk_f) begin
    logic [46:0] got, exp_v;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      got = {tx_data_out, tx_valid_out, state_out, link_up, usr_ready_out, sincronizar_bus, retrain_count, train_timeout};
      n_chk++;
      if (got === exp_v) n_pass++;
      else $display("FAIL cycle %0d outputs {txd,txv,st,lu,rdy,sync,rc,to}: got %h expected %h", cyc_no, got, exp_v);
      cyc_no++;
    end
  end
  initial begin
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    hold(1'b1, 40);
    cyc(1'b1, 1'b1);
    hold(1'b1, 14);
    hold(1'b0, 1);
    hold(1'b1, 20);
    hold(1'b0, 3);
    hold(1'b1, 10);
    hold(1'b0, 7);
    hold(1'b1, 10);
    hold(1'b0, 8);
    hold(1'b1, 30);
    hold(1'b0, 300);
    cyc(1'b1, 1'b0);
    hold(1'b1, 30);
    for (int k = 0; k < 60; k++) begin
      hold(1'b1, $urandom_range(1, 40));
      hold(1'b0, $urandom_range(1, 12));
    end
    for (int k = 0; k < 260; k++) begin
      hold(1'b0, 8);
      hold(1'b1, 20);
    end
    for (int k = 0; k < 500; k++) cyc(1'b0, $urandom_range(0, 9) != 0);
    cyc(1'b1, 1'b1);
    hold(1'b1, 5);
    repeat (3) @(posedge clk_f);
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
